uart_core: RTL and testbench
============================

# uart_core

Full-duplex, parametrised UART core that replaces the fixed 8N1 transmitter/receiver pair. It adds configurable data width, parity and stop bits, and an oversampled receiver with majority voting. It also reports framing, parity and overrun errors, and uses valid/ready handshakes on both directions. It sits between the bus-side peripheral register file and the board TX/RX pins.

## Interface
- CLK_GEN, 12000000: system clock frequency in Hz.
- BAUD, 115200: line rate in baud.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2; any other value is illegal.
- OVERSAMPLE, 16: RX samples per bit; even, ≥ 8.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  word to transmit; sampled on handshake.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter idle and able to accept a word.
- tx  out  1  serial output; idle high.
- rx  in  1  serial input; asynchronous to clk.
- rx_data  out  DATA_BITS  last received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer takes rx_data.
- frame_err  out  1  stop bit of the word in rx_data was sampled 0.
- parity_err  out  1  parity mismatch on the word in rx_data; always 0 when PARITY = 0.
- overrun  out  1  one-cycle pulse: a frame completed while rx_valid was high.

## Operation
- Tick generator:
  - OS_DIV = CLK_GEN/(BAUD*OVERSAMPLE), integer division, minimum 1.
  - The free-running divider emits a one-clock os_tick every OS_DIV clocks.
  - Bit time T = OVERSAMPLE*OS_DIV clocks.
- TX FSM, states IDLE → START → DATA → PARITY (skipped if PARITY = 0) → STOP → IDLE.
  - Handshake: a word is accepted on a cycle with tx_valid && tx_ready.
  - Data bits are sent LSB first.
  - Parity bit is odd or even over the DATA_BITS bits.
  - STOP lasts STOP_BITS*T.
  - tx is registered, so it is glitch-free.
- RX synchronisation: rx passes through a 2-flop synchroniser before any use.
- RX FSM, states IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: a synchronised falling edge starts the os_tick counter.
  - START: start bit is checked at sample OVERSAMPLE/2. If high, it is a false start and the FSM returns to IDLE with no output.
  - Bit value: each data, parity and stop bit is the majority of samples OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - STOP: only the first stop bit is checked. The FSM returns to IDLE right after that bit's mid-point, so back-to-back frames are resynchronised.
- Frame completion at the stop mid-point:
  - If rx_valid = 0: load rx_data, frame_err and parity_err, and set rx_valid.
  - If rx_valid = 1: discard the new frame, pulse overrun, and hold rx_data and the flags unchanged.
- rx_valid clears on the cycle after rx_valid && rx_ready.
- Simultaneous completion and consume in the same cycle: the new frame loads, rx_valid stays 1, no overrun.
- A frame with frame_err is still delivered.
- A break (rx low for a whole frame) delivers rx_data = 0 with frame_err = 1. The next frame is not accepted until rx has been seen high.

## Timing
- Reset values: tx = 1, tx_ready = 1, rx_valid = 0, rx_data = 0, frame_err = 0, parity_err = 0, overrun = 0. Both FSMs are in IDLE and all counters are 0.
- Reset mid-frame: on rst_n low, tx returns to 1 immediately and any partial frame is discarded.
- TX latency:
  - tx_ready falls the cycle after acceptance; tx goes low on that same cycle.
  - Frame length F = T*(1+DATA_BITS+(PARITY≠0)+STOP_BITS) clocks.
  - tx_ready rises exactly F clocks after it fell.
  - Back-to-back words are possible with tx_valid held high: no idle gap beyond the stop bits.
- RX latency: rx_valid rises 3 clocks (2 synchroniser + 1 register) after the stop-bit mid-point sample, measured from the rx pin.
- Tolerance: the receiver accepts up to ±3% baud mismatch at 8N1.

## Test plan
Bench parameters: CLK_GEN = 1843200, BAUD = 115200, OVERSAMPLE = 16, so OS_DIV = 1 and T = 16 clocks.
- TX 8N1: send 0xA5 → tx low 16 clocks, then 1,0,1,0,0,1,0,1 (16 clocks each), then high. tx_ready is low for 160 clocks.
- Loopback tx→rx, PARITY = 2: send 0x37 → parity bit 1; rx_valid = 1, rx_data = 0x37, frame_err = 0, parity_err = 0.
- Glitch: drive rx low for 4 clocks, then high → no rx_valid, RX back in IDLE, a following 0x5A is received correctly.
- Framing and parity errors:
  - Drive 8N1 frame 0x3C with stop bit 0 → rx_valid = 1, rx_data = 0x3C, frame_err = 1.
  - PARITY = 1, frame 0x01 with parity bit 1 → parity_err = 1.
- Overrun: rx_ready = 0, receive 0x11 then 0x22 → rx_data = 0x11 and overrun pulses once at the second stop mid-point. Raise rx_ready → rx_valid clears next cycle.
- Reset mid-TX: assert rst_n low during data bit 4 of 0xFF → tx = 1 and tx_ready = 1 while in reset. After release, a new 0x80 transmits cleanly.

Source files
------------

// File: rtl/uart_core_if.sv
// Bus-side handshake bundle for uart_core: TX word input, RX word output
// and the receive status flags. The core connects through the slave modport;
// the peripheral register file (or a bench) drives the master side.
interface uart_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, frame_err, parity_err, overrun
  );

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_core.sv
// Full-duplex UART core: configurable data width, parity and stop bits,
// clock-exact transmitter, 16x-style oversampled receiver with 3-sample
// majority voting, framing/parity/overrun reporting, valid/ready on both sides.
module uart_core #(
  parameter int CLK_GEN    = 12000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_core_if.slave bus,
  output logic       tx,
  input  logic       rx
);
  localparam int OS_DIV_RAW = CLK_GEN / (BAUD * OVERSAMPLE);
  localparam int OS_DIV     = (OS_DIV_RAW < 1) ? 1 : OS_DIV_RAW;
  localparam int T          = OVERSAMPLE * OS_DIV;
  localparam int DW         = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int TW         = (T > 1) ? $clog2(T) : 1;
  localparam int SW         = $clog2(OVERSAMPLE);
  localparam int IW         = 4;

  // Parity bit that accompanies a data word (odd or even over all data bits)
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // ---------------- oversample tick generator ----------------
  logic [DW-1:0] div_q, div_d;
  logic          os_tick;

  // Free-running divider: one os_tick every OS_DIV clocks
  always_comb begin
    os_tick = (div_q == DW'(OS_DIV - 1));
    div_d   = os_tick ? '0 : div_q + 1'b1;
  end

  // Divider register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

  // ---------------- transmitter ----------------
  // TX counts raw clocks per bit (not os_ticks) so every bit is exactly T
  // clocks long regardless of where the word was accepted.
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  tx_state_t            txs_q, txs_d;
  logic [TW-1:0]        tclk_q, tclk_d;
  logic [IW-1:0]        tidx_q, tidx_d;
  logic [DATA_BITS-1:0] tsh_q, tsh_d;
  logic                 tpar_q, tpar_d;
  logic                 tx_q, tx_d;
  logic                 tbit_end;

  // TX next-state: tx_d is computed alongside the state so the line is registered
  always_comb begin
    txs_d    = txs_q;
    tclk_d   = tclk_q;
    tidx_d   = tidx_q;
    tsh_d    = tsh_q;
    tpar_d   = tpar_q;
    tx_d     = tx_q;
    tbit_end = (tclk_q == TW'(T - 1));
    if (txs_q != TX_IDLE) tclk_d = tbit_end ? '0 : tclk_q + 1'b1;
    unique case (txs_q)
      TX_IDLE: begin
        if (bus.tx_valid) begin
          txs_d  = TX_START;
          tclk_d = '0;
          tidx_d = '0;
          tsh_d  = bus.tx_data;
          tpar_d = parity_of(bus.tx_data);
          tx_d   = 1'b0;
        end
      end
      TX_START: begin
        if (tbit_end) begin
          txs_d = TX_DATA;
          tx_d  = tsh_q[0];
        end
      end
      TX_DATA: begin
        if (tbit_end) begin
          if (tidx_q == IW'(DATA_BITS - 1)) begin
            tidx_d = '0;
            if (PARITY != 0) begin
              txs_d = TX_PAR;
              tx_d  = tpar_q;
            end else begin
              txs_d = TX_STOP;
              tx_d  = 1'b1;
            end
          end else begin
            tidx_d = tidx_q + 1'b1;
            tsh_d  = tsh_q >> 1;
            tx_d   = tsh_q[1];
          end
        end
      end
      TX_PAR: begin
        if (tbit_end) begin
          txs_d  = TX_STOP;
          tidx_d = '0;
          tx_d   = 1'b1;
        end
      end
      TX_STOP: begin
        if (tbit_end) begin
          if (tidx_q == IW'(STOP_BITS - 1)) begin
            txs_d  = TX_IDLE;
            tidx_d = '0;
          end else begin
            tidx_d = tidx_q + 1'b1;
          end
        end
      end
      default: txs_d = TX_IDLE;
    endcase
  end

  // TX state and line registers; reset forces the line idle-high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txs_q  <= TX_IDLE;
      tclk_q <= '0;
      tidx_q <= '0;
      tsh_q  <= '0;
      tpar_q <= 1'b0;
      tx_q   <= 1'b1;
    end else begin
      txs_q  <= txs_d;
      tclk_q <= tclk_d;
      tidx_q <= tidx_d;
      tsh_q  <= tsh_d;
      tpar_q <= tpar_d;
      tx_q   <= tx_d;
    end
  end

  assign tx           = tx_q;
  assign bus.tx_ready = (txs_q == TX_IDLE);

  // ---------------- receiver ----------------
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  rx_state_t            rxs_q, rxs_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [IW-1:0]        ridx_q, ridx_d;
  logic [DATA_BITS-1:0] rsh_q, rsh_d;
  logic [1:0]           vote_q, vote_d;
  logic                 rpar_q, rpar_d;
  logic                 maj, at_v0, at_mid, at_v2, at_end;
  logic                 done, done_fe, done_pe;

  // RX next-state: samp_q is the index of the sample taken at the next tick;
  // a bit's value is decided at sample OVERSAMPLE/2+1 from three votes
  always_comb begin
    rxs_d   = rxs_q;
    samp_d  = samp_q;
    ridx_d  = ridx_q;
    rsh_d   = rsh_q;
    vote_d  = vote_q;
    rpar_d  = rpar_q;
    done    = 1'b0;
    done_fe = 1'b0;
    done_pe = 1'b0;
    maj     = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s2_q) | (vote_q[1] & rx_s2_q);
    at_v0   = os_tick && (samp_q == SW'(OVERSAMPLE/2 - 1));
    at_mid  = os_tick && (samp_q == SW'(OVERSAMPLE/2));
    at_v2   = os_tick && (samp_q == SW'(OVERSAMPLE/2 + 1));
    at_end  = os_tick && (samp_q == SW'(OVERSAMPLE - 1));
    if (rxs_q != RX_IDLE && os_tick) samp_d = at_end ? '0 : samp_q + 1'b1;
    if (at_v0)  vote_d[0] = rx_s2_q;
    if (at_mid) vote_d[1] = rx_s2_q;
    unique case (rxs_q)
      RX_IDLE: begin
        // Needs a real high-to-low transition, so a break cannot retrigger
        if (rx_prev_q && !rx_s2_q) begin
          rxs_d  = RX_START;
          samp_d = SW'(1);
          ridx_d = '0;
        end
      end
      RX_START: begin
        if (at_mid && rx_s2_q) begin
          rxs_d  = RX_IDLE;
          samp_d = '0;
        end else if (at_end) begin
          rxs_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (at_v2) rsh_d = {maj, rsh_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (ridx_q == IW'(DATA_BITS - 1)) begin
            ridx_d = '0;
            rxs_d  = (PARITY != 0) ? RX_PAR : RX_STOP;
          end else begin
            ridx_d = ridx_q + 1'b1;
          end
        end
      end
      RX_PAR: begin
        if (at_v2)  rpar_d = maj;
        if (at_end) rxs_d  = RX_STOP;
      end
      RX_STOP: begin
        // Leave right after the first stop bit's vote to resync on the next start
        if (at_v2) begin
          done    = 1'b1;
          done_fe = ~maj;
          done_pe = (PARITY == 1) ? ~(^rsh_q ^ rpar_q) :
                    (PARITY == 2) ?  (^rsh_q ^ rpar_q) : 1'b0;
          rxs_d   = RX_IDLE;
          samp_d  = '0;
        end
      end
      default: rxs_d = RX_IDLE;
    endcase
  end

  // RX state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxs_q  <= RX_IDLE;
      samp_q <= '0;
      ridx_q <= '0;
      rsh_q  <= '0;
      vote_q <= '0;
      rpar_q <= 1'b0;
    end else begin
      rxs_q  <= rxs_d;
      samp_q <= samp_d;
      ridx_q <= ridx_d;
      rsh_q  <= rsh_d;
      vote_q <= vote_d;
      rpar_q <= rpar_d;
    end
  end

  logic [DATA_BITS-1:0] rxd_q, rxd_d;
  logic                 vld_q, vld_d, fe_q, fe_d, pe_q, pe_d, ovr_q, ovr_d;
  logic                 consume;

  // Output holding register: load when empty or being consumed, else flag overrun
  always_comb begin
    rxd_d   = rxd_q;
    vld_d   = vld_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    ovr_d   = 1'b0;
    consume = vld_q && bus.rx_ready;
    if (done) begin
      if (!vld_q || consume) begin
        rxd_d = rsh_q;
        fe_d  = done_fe;
        pe_d  = done_pe;
        vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (consume) begin
      vld_d = 1'b0;
    end
  end

  // Output holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_q <= '0;
      vld_q <= 1'b0;
      fe_q  <= 1'b0;
      pe_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      rxd_q <= rxd_d;
      vld_q <= vld_d;
      fe_q  <= fe_d;
      pe_q  <= pe_d;
      ovr_q <= ovr_d;
    end
  end

  assign bus.rx_data    = rxd_q;
  assign bus.rx_valid   = vld_q;
  assign bus.frame_err  = fe_q;
  assign bus.parity_err = pe_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core at T = 16 clocks (1843200 Hz / 115200 baud / 16x).
// Three cores: 8N1 (TX waveform, RX errors, overrun, reset), 8E1 in loopback,
// and 8O1 for odd-parity checking.
module tb_uart_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_n, rx_n, lb_e, tx_o, rx_o;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ovr_cnt_n = 0;
  logic [9:0] exp_n[$];
  logic [9:0] exp_e[$];
  logic [9:0] exp_o[$];

  always #5 clk = ~clk;

  uart_core_if #(.DATA_BITS(8)) if_n ();
  uart_core_if #(.DATA_BITS(8)) if_e ();
  uart_core_if #(.DATA_BITS(8)) if_o ();

  uart_core #(.CLK_GEN(1843200), .BAUD(115200), .DATA_BITS(8), .PARITY(0),
              .STOP_BITS(1), .OVERSAMPLE(16))
    dut_n (.clk(clk), .rst_n(rst_n), .bus(if_n), .tx(tx_n), .rx(rx_n));
  uart_core #(.CLK_GEN(1843200), .BAUD(115200), .DATA_BITS(8), .PARITY(2),
              .STOP_BITS(1), .OVERSAMPLE(16))
    dut_e (.clk(clk), .rst_n(rst_n), .bus(if_e), .tx(lb_e), .rx(lb_e));
  uart_core #(.CLK_GEN(1843200), .BAUD(115200), .DATA_BITS(8), .PARITY(1),
              .STOP_BITS(1), .OVERSAMPLE(16))
    dut_o (.clk(clk), .rst_n(rst_n), .bus(if_o), .tx(tx_o), .rx(rx_o));

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Scoreboard monitors: compare each word as it is handed over
  always @(negedge clk) begin
    if (rst_n && if_n.rx_valid && if_n.rx_ready) begin
      if (exp_n.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL n_rx_extra: got %0h, nothing expected", if_n.rx_data);
      end else chk("n_rx_word", 32'({if_n.rx_data, if_n.frame_err, if_n.parity_err}),
                   32'(exp_n.pop_front()));
    end
    if (rst_n && if_n.overrun) ovr_cnt_n++;
  end

  always @(negedge clk) begin
    if (rst_n && if_e.rx_valid && if_e.rx_ready) begin
      if (exp_e.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL e_rx_extra: got %0h, nothing expected", if_e.rx_data);
      end else chk("e_rx_word", 32'({if_e.rx_data, if_e.frame_err, if_e.parity_err}),
                   32'(exp_e.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_o.rx_valid && if_o.rx_ready) begin
      if (exp_o.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL o_rx_extra: got %0h, nothing expected", if_o.rx_data);
      end else chk("o_rx_word", 32'({if_o.rx_data, if_o.frame_err, if_o.parity_err}),
                   32'(exp_o.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rx(input int which, input logic b, input int clocks);
    if (which == 0) rx_n = b;
    else            rx_o = b;
    repeat (clocks) @(posedge clk);
    #1;
  endtask

  // par < 0 means no parity bit
  task automatic send_frame(input int which, input logic [7:0] d, input int par, input logic stopb);
    drive_rx(which, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive_rx(which, d[i], 16);
    if (par >= 0) drive_rx(which, par[0], 16);
    drive_rx(which, stopb, 16);
  endtask

  function automatic int qsize(input int which);
    if (which == 0) return exp_n.size();
    if (which == 1) return exp_e.size();
    return exp_o.size();
  endfunction

  task automatic wait_empty(input int which, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (qsize(which) == 0) break;
      tick();
    end
    chk({tag, "_drained"}, 32'(qsize(which)), 32'd0);
  endtask

  // Send one word on the 8N1 core and check every clock of the frame
  task automatic tx_check(input logic [7:0] d, input string tag);
    logic [9:0] bits;
    logic [1:0] seen;
    int         low;
    bits = {1'b1, d, 1'b0};
    if_n.tx_data  = d;
    if_n.tx_valid = 1'b1;
    tick();
    if_n.tx_valid = 1'b0;
    low = 0;
    for (int k = 0; k < 10; k++) begin
      seen = 2'b00;
      for (int j = 0; j < 16; j++) begin
        seen |= tx_n ? 2'b10 : 2'b01;
        if (!if_n.tx_ready) low++;
        tick();
      end
      chk($sformatf("%s_bit%0d", tag, k), 32'(seen), bits[k] ? 32'd2 : 32'd1);
    end
    for (int j = 0; j < 64 && !if_n.tx_ready; j++) begin
      low++;
      tick();
    end
    chk({tag, "_ready_low"}, 32'(low), 32'd160);
    chk({tag, "_idle_high"}, 32'(tx_n), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_tx"},       32'(tx_n),            32'd1);
    chk({tag, "_tx_ready"}, 32'(if_n.tx_ready),   32'd1);
    chk({tag, "_rx_valid"}, 32'(if_n.rx_valid),   32'd0);
    chk({tag, "_rx_data"},  32'(if_n.rx_data),    32'd0);
    chk({tag, "_flags"},    32'({if_n.frame_err, if_n.parity_err, if_n.overrun}), 32'd0);
    chk({tag, "_lb_tx"},    32'(lb_e),            32'd1);
  endtask

  initial begin
    rx_n = 1'b1; rx_o = 1'b1;
    if_n.tx_data = '0; if_n.tx_valid = 1'b0; if_n.rx_ready = 1'b1;
    if_e.tx_data = '0; if_e.tx_valid = 1'b0; if_e.rx_ready = 1'b1;
    if_o.tx_data = '0; if_o.tx_valid = 1'b0; if_o.rx_ready = 1'b1;
    repeat (3) tick();
    check_reset_state("rst");
    rst_n = 1'b1;
    repeat (4) tick();

    // TX 8N1 waveform
    tx_check(8'hA5, "txA5");

    // Loopback with even parity: 0x37 has five ones, so the parity bit is 1
    exp_e.push_back({8'h37, 1'b0, 1'b0});
    if_e.tx_data  = 8'h37;
    if_e.tx_valid = 1'b1;
    tick();
    if_e.tx_valid = 1'b0;
    repeat (16 * 9 + 8) tick();
    chk("lb_parity_bit", 32'(lb_e), 32'd1);
    wait_empty(1, 300, "lb");

    // Short glitch is rejected, then a real frame is received
    drive_rx(0, 1'b0, 4);
    drive_rx(0, 1'b1, 40);
    chk("glitch_no_valid", 32'(if_n.rx_valid), 32'd0);
    exp_n.push_back({8'h5A, 1'b0, 1'b0});
    send_frame(0, 8'h5A, -1, 1'b1);
    drive_rx(0, 1'b1, 32);
    wait_empty(0, 100, "g5A");

    // Framing error: stop bit driven low, word still delivered
    exp_n.push_back({8'h3C, 1'b1, 1'b0});
    send_frame(0, 8'h3C, -1, 1'b0);
    drive_rx(0, 1'b1, 32);
    wait_empty(0, 100, "fe3C");

    // Break: one all-zero word with frame_err, then nothing until rx goes high
    exp_n.push_back({8'h00, 1'b1, 1'b0});
    drive_rx(0, 1'b0, 400);
    drive_rx(0, 1'b1, 32);
    wait_empty(0, 100, "brk");
    exp_n.push_back({8'h81, 1'b0, 1'b0});
    send_frame(0, 8'h81, -1, 1'b1);
    drive_rx(0, 1'b1, 32);
    wait_empty(0, 100, "brk81");

    // Odd parity: 0x01 with parity 1 is wrong, with parity 0 is right
    exp_o.push_back({8'h01, 1'b0, 1'b1});
    send_frame(1, 8'h01, 1, 1'b1);
    drive_rx(1, 1'b1, 32);
    wait_empty(2, 100, "po_bad");
    exp_o.push_back({8'h01, 1'b0, 1'b0});
    send_frame(1, 8'h01, 0, 1'b1);
    drive_rx(1, 1'b1, 32);
    wait_empty(2, 100, "po_good");

    // Overrun: second word discarded while the first is unconsumed
    if_n.rx_ready = 1'b0;
    ovr_cnt_n = 0;
    exp_n.push_back({8'h11, 1'b0, 1'b0});
    send_frame(0, 8'h11, -1, 1'b1);
    send_frame(0, 8'h22, -1, 1'b1);
    drive_rx(0, 1'b1, 32);
    chk("ovr_pulses", 32'(ovr_cnt_n), 32'd1);
    chk("ovr_hold_valid", 32'(if_n.rx_valid), 32'd1);
    chk("ovr_hold_data", 32'(if_n.rx_data), 32'h11);
    if_n.rx_ready = 1'b1;
    tick();
    chk("ovr_valid_clear", 32'(if_n.rx_valid), 32'd0);
    chk("ovr_drained", 32'(exp_n.size()), 32'd0);

    // Reset during data bit 4 of 0xFF
    if_n.tx_data  = 8'hFF;
    if_n.tx_valid = 1'b1;
    tick();
    if_n.tx_valid = 1'b0;
    repeat (16 * 5 + 5) tick();
    chk("pre_rst_tx_busy", 32'(if_n.tx_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx_n), 32'd1);
    chk("mid_rst_ready", 32'(if_n.tx_ready), 32'd1);
    repeat (3) tick();
    check_reset_state("rst2");
    rst_n = 1'b1;
    repeat (2) tick();
    tx_check(8'h80, "tx80");

    repeat (40) tick();
    chk("o_tx_idle", 32'(tx_o), 32'd1);
    chk("end_sb_n", 32'(exp_n.size()), 32'd0);
    chk("end_sb_e", 32'(exp_e.size()), 32'd0);
    chk("end_sb_o", 32'(exp_o.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
